// File: rtl/edge_capture_pkg.sv
// Shared types for the edge capture sequencer.
//   cap_state_t : sequencer FSM states
//   trig_mode_t : trigger source select
//   trig_hit()  : picks the detector strobe that matches a trigger mode
package edge_capture_pkg;

  typedef enum logic [2:0] {IDLE, ARMED, WAIT, CAPTURE, DONE} cap_state_t;
  typedef enum logic [1:0] {TRIG_RISE, TRIG_FALL, TRIG_ANY, TRIG_OFF} trig_mode_t;

  function automatic logic trig_hit(trig_mode_t m, logic pos, logic neg, logic chg);
    case (m)
      TRIG_RISE: return pos;
      TRIG_FALL: return neg;
      TRIG_ANY:  return chg;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/edge_capture_ctrl_sync_fifo.sv
// Single-clock FIFO holding captured words.
//   i_clk, i_rst   : clock, synchronous active-high reset (flushes pointers)
//   i_push, i_din  : write request and word
//   i_pop          : read request (ignored while empty)
//   o_full/o_empty : occupancy flags from the extra pointer MSB
//   o_head         : word at the read pointer, 0 while empty
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr, r_rptr;
  logic             w_do_push, w_do_pop;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push then.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  assign o_head = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage needs no reset: o_head is masked while empty.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/edge_capture_ctrl.sv
// Capture sequencer: arms on command, waits for the selected detector strobe,
// aligns to the delay pipeline latency, then captures a burst of pipeline words
// into a FIFO drained over valid/ready.
//   i_clk, i_rst           : clock, synchronous active-high reset
//   i_arm, i_abort, i_mode : control (arm in IDLE only; abort from any state)
//   i_pos/neg/chg_det      : detector strobes
//   i_pipe_data            : delay pipeline output
//   o_pulse_en             : pulse generator enable (CAPTURE only)
//   o_out_valid/i_out_ready/o_out_data : FIFO drain handshake
//   o_busy, o_done, o_overflow : status
module edge_capture_ctrl
  import edge_capture_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int PIPE_DEPTH = 3,
  parameter int BURST_LEN  = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_arm,
  input  logic              i_abort,
  input  logic [1:0]        i_mode,
  input  logic              i_pos_det,
  input  logic              i_neg_det,
  input  logic              i_chg_det,
  input  logic [DATA_W-1:0] i_pipe_data,
  output logic              o_pulse_en,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_overflow
);
  // WAIT lasts PIPE_DEPTH-1 cycles; the counter runs load..0.
  localparam logic [3:0] WAIT_LOAD = 4'((PIPE_DEPTH > 1) ? PIPE_DEPTH - 2 : 0);
  localparam logic [7:0] CAP_LAST  = 8'(BURST_LEN - 1);

  cap_state_t r_state, w_next;
  trig_mode_t r_mode_q;
  logic [3:0] r_wait_cnt;
  logic [7:0] r_cap_cnt;
  logic       r_overflow;
  logic       w_arm_ok, w_trig, w_push, w_pop, w_full, w_empty, w_drop;

  assign w_arm_ok = (r_state == IDLE) & i_arm & ~i_abort;
  assign w_trig   = trig_hit(r_mode_q, i_pos_det, i_neg_det, i_chg_det);

  // The aborting cycle does not push, so an aborted burst keeps only the
  // words captured before the abort request.
  assign w_push = (r_state == CAPTURE) & ~i_abort;
  assign w_pop  = ~w_empty & i_out_ready;
  assign w_drop = w_push & w_full & ~w_pop;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_arm) w_next = ARMED;
      ARMED:   if (w_trig) w_next = (PIPE_DEPTH > 1) ? WAIT : CAPTURE;
      WAIT:    if (r_wait_cnt == 4'd0) w_next = CAPTURE;
      CAPTURE: if (r_cap_cnt == CAP_LAST) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (i_abort) w_next = IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_mode_q   <= TRIG_RISE;
      r_wait_cnt <= '0;
      r_cap_cnt  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_arm_ok) r_mode_q <= trig_mode_t'(i_mode);
      // Counters idle at their start value, so no state entry needs to load them.
      r_wait_cnt <= (r_state == WAIT) ? r_wait_cnt - 4'd1 : WAIT_LOAD;
      r_cap_cnt  <= (r_state == CAPTURE) ? r_cap_cnt + 8'd1 : 8'd0;
      if (w_arm_ok)    r_overflow <= 1'b0;
      else if (w_drop) r_overflow <= 1'b1;
    end
  end

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_push (w_push),
    .i_din  (i_pipe_data),
    .i_pop  (w_pop),
    .o_full (w_full),
    .o_empty(w_empty),
    .o_head (o_out_data)
  );

  assign o_pulse_en  = (r_state == CAPTURE);
  assign o_out_valid = ~w_empty;
  assign o_busy      = (r_state != IDLE);
  assign o_done      = (r_state == DONE);
  assign o_overflow  = r_overflow;

endmodule
